// File: rtl/instr_fetch_unit_pkg.sv
// pa_riscv: shared fetch-path types and constants
package pa_riscv;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetchEntry_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered FIFO of fetched {pc, instruction} entries with flush
module fetch_fifo
  import pa_riscv::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetchEntry_t   pushData,
  input  logic          pop,
  output fetchEntry_t   head,
  output logic [CW-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  fetchEntry_t mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr <= wrPtr == LAST ? '0 : wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr == LAST ? '0 : rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rdPtr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited instruction fetch with redirect flush/discard
module instr_fetch_unit
  import pa_riscv::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  output logic        o_memReq,
  output logic [31:0] o_memAddr,
  input  logic        i_memGnt,
  input  logic        i_memRValid,
  input  logic [31:0] i_memRData,
  output logic        o_instrValid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_instrPc,
  input  logic        i_instrReady
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  logic [31:0] fetchPc, respPc, target;
  logic [CW-1:0] outstanding, discard, count;
  logic gnt, drop, push, pop;
  fetchEntry_t head, pushData;
  // buffered plus in-flight words never exceed the buffer, so pushes always fit
  assign o_memReq = !i_arst && !i_redirect && ({1'b0, outstanding} + {1'b0, count} < DEPTH_C);
  assign o_memAddr = fetchPc;
  assign gnt = o_memReq && i_memGnt;
  assign drop = discard != '0;
  assign push = i_memRValid && !drop && !i_redirect;
  assign pop = o_instrValid && i_instrReady && !i_redirect;
  assign target = i_redirectPc & ~32'h3;
  assign pushData = '{pc: respPc, instruction: i_memRData};
  assign o_instrValid = count != '0;
  assign o_instruction = head.instruction;
  assign o_instrPc = head.pc;
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      fetchPc <= RESET_PC;
      respPc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
    end else if (i_redirect) begin
      fetchPc <= target;
      respPc <= target;
      outstanding <= outstanding - CW'(i_memRValid);
      discard <= outstanding - CW'(i_memRValid);
    end else begin
      if (gnt) fetchPc <= fetchPc + INSTR_BYTES;
      if (push) respPc <= respPc + INSTR_BYTES;
      if (i_memRValid && drop) discard <= discard - 1'b1;
      outstanding <= outstanding + CW'(gnt) - CW'(i_memRValid);
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_arst),
    .flush(i_redirect),
    .push(push),
    .pushData(pushData),
    .pop(pop),
    .head(head),
    .count(count)
  );
  assert property (@(posedge i_clk) disable iff (i_arst) i_memRValid |-> outstanding != '0);
endmodule
